// File: rtl/i2c_line_bank.sv
// Bank of open-drain lines with per-line synchroniser, hysteretic saturating-integrator
// deglitcher, registered edge strobes and a released-but-held-low flag.
module i2c_line_bank #(
  parameter int unsigned N_LINES    = 2,
  parameter int unsigned SYN_STAGES = 2,
  parameter int unsigned FLT_LEN    = 3,
  parameter bit          IDLE_LEVEL = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tickX16,
  input  logic [N_LINES-1:0] lineOut,
  output logic [N_LINES-1:0] lineFlt,
  output logic [N_LINES-1:0] lineRise,
  output logic [N_LINES-1:0] lineFall,
  output logic [N_LINES-1:0] lineHeld,
  inout  wire  [N_LINES-1:0] lines
);

  localparam int unsigned    CW      = $clog2(FLT_LEN + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(FLT_LEN);
  localparam logic [CW-1:0]  CNT_ONE = CW'(1);
  localparam logic [CW-1:0]  CNT_RST = IDLE_LEVEL ? CNT_MAX : '0;

  logic [N_LINES-1:0][SYN_STAGES-1:0] syn_q;
  logic [N_LINES-1:0][CW-1:0]         cnt_q;

  // Open-drain: only ever pull low; the pin itself is the sole input source.
  for (genvar g = 0; g < N_LINES; g++) begin : g_pad
    assign lines[g] = lineOut[g] ? 1'bz : 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(N_LINES); i++) begin
        syn_q[i] <= {SYN_STAGES{IDLE_LEVEL}};
        cnt_q[i] <= CNT_RST;
      end
      lineFlt  <= {N_LINES{IDLE_LEVEL}};
      lineRise <= '0;
      lineFall <= '0;
      lineHeld <= '0;
    end else begin
      for (int i = 0; i < int'(N_LINES); i++) begin
        syn_q[i] <= {syn_q[i][SYN_STAGES-2:0], lines[i]};
        // Saturating integrator: never wraps at either end.
        if (tickX16) begin
          if (syn_q[i][SYN_STAGES-1] && (cnt_q[i] != CNT_MAX)) begin
            cnt_q[i] <= cnt_q[i] + CNT_ONE;
          end else if (!syn_q[i][SYN_STAGES-1] && (cnt_q[i] != '0)) begin
            cnt_q[i] <= cnt_q[i] - CNT_ONE;
          end
        end
        // Hysteresis: only the saturation points move the filtered level.
        if (cnt_q[i] == CNT_MAX) begin
          lineFlt[i] <= 1'b1;
        end else if (cnt_q[i] == '0) begin
          lineFlt[i] <= 1'b0;
        end
        lineRise[i] <= (cnt_q[i] == CNT_MAX) & ~lineFlt[i];
        lineFall[i] <= (cnt_q[i] == '0) & lineFlt[i];
      end
      lineHeld <= lineOut & ~lineFlt;
    end
  end

endmodule

// File: tb/tb_i2c_line_bank.sv
// Directed bench for i2c_line_bank: a default 2-line bank and a 4-line, 3-stage bank
// sharing clock, reset and a tick every fourth clk.
module tb_i2c_line_bank;

  logic       clk     = 1'b0;
  logic       reset   = 1'b1;
  logic       tick    = 1'b0;
  logic [1:0] out_a   = 2'b11;
  logic [1:0] drv_a   = 2'b00;
  logic [3:0] out_b   = 4'hf;
  logic [3:0] drv_b   = 4'h0;
  wire  [1:0] flt_a, rise_a, fall_a, held_a, lines_a;
  wire  [3:0] flt_b, rise_b, fall_b, held_b, lines_b;

  int  n_vec   = 0;
  int  n_err   = 0;
  int  phase   = 0;
  bit  tick_on = 1'b1;
  int  lat;
  int  tf[4], nf[4], nr[4];
  logic ok;

  for (genvar g = 0; g < 2; g++) begin : g_pa
    assign lines_a[g] = drv_a[g] ? 1'b0 : 1'bz;
    pullup (lines_a[g]);
  end
  for (genvar g = 0; g < 4; g++) begin : g_pb
    assign lines_b[g] = drv_b[g] ? 1'b0 : 1'bz;
    pullup (lines_b[g]);
  end

  i2c_line_bank u_dut_a (
    .clk      (clk),
    .reset    (reset),
    .tickX16  (tick),
    .lineOut  (out_a),
    .lineFlt  (flt_a),
    .lineRise (rise_a),
    .lineFall (fall_a),
    .lineHeld (held_a),
    .lines    (lines_a)
  );

  i2c_line_bank #(
    .N_LINES    (4),
    .SYN_STAGES (3)
  ) u_dut_b (
    .clk      (clk),
    .reset    (reset),
    .tickX16  (tick),
    .lineOut  (out_b),
    .lineFlt  (flt_b),
    .lineRise (rise_b),
    .lineFall (fall_b),
    .lineHeld (held_b),
    .lines    (lines_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clk; sample point is 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    phase = (phase + 1) % 4;
    tick  = tick_on && (phase == 0);
  endtask

  // Next edge carries a tick, then every fourth edge.
  task automatic align();
    phase = 0;
    tick  = tick_on;
  endtask

  task automatic wait_edge(input bit want_rise, input int idx, input int maxc, output int l);
    logic [1:0] v;
    l = -1;
    for (int k = 1; k <= maxc; k++) begin
      step();
      v = want_rise ? rise_a : fall_a;
      if (v[idx]) begin
        l = k;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_flt_a", flt_a, 2'b11);
    check("rst_rise_a", rise_a, 0);
    check("rst_fall_a", fall_a, 0);
    check("rst_held_a", held_a, 0);
    check("rst_lines_a", lines_a, 2'b11);
    check("rst_flt_b", flt_b, 4'hf);
    reset = 1'b0;
    align();
    repeat (10) step();
    check("idle_flt_a", flt_a, 2'b11);
    check("idle_held_a", held_a, 0);

    out_a[0] = 1'b0;
    #1;
    check("drive_low", lines_a[0], 0);
    out_a[0] = 1'b1;
    #1;
    check("drive_release", lines_a, 2'b11);

    // 2-tick low glitch must not reach the filtered level.
    align();
    ok = 1'b0;
    drv_a[0] = 1'b1;
    repeat (8) begin step(); ok |= fall_a[0]; end
    drv_a[0] = 1'b0;
    repeat (20) begin step(); ok |= fall_a[0] | ~flt_a[0]; end
    check("glitch_nofall", ok, 0);
    check("glitch_flt", flt_a[0], 1);

    // Clean fall/rise; a latency of 14 also proves the counter was back at 3.
    align();
    drv_a[0] = 1'b1;
    wait_edge(1'b0, 0, 40, lat);
    check("fall_lat", lat, 14);
    check("fall_flt", flt_a[0], 0);
    step();
    check("fall_pulse", fall_a[0], 0);
    check("held0_set", held_a[0], 1);
    repeat (4) step();
    align();
    drv_a[0] = 1'b0;
    wait_edge(1'b1, 0, 40, lat);
    check("rise_lat", lat, 14);
    check("rise_flt", flt_a[0], 1);
    step();
    check("rise_pulse", rise_a[0], 0);
    check("held0_clr", held_a[0], 0);

    // No ticks: filter frozen.
    tick_on = 1'b0;
    align();
    drv_a[0] = 1'b1;
    repeat (40) step();
    check("freeze_flt", flt_a[0], 1);
    drv_a[0] = 1'b0;
    tick_on = 1'b1;
    repeat (4) step();

    // Clock stretch on line 1.
    align();
    drv_a[1] = 1'b1;
    wait_edge(1'b0, 1, 40, lat);
    check("scl_fall_lat", lat, 14);
    ok = 1'b1;
    repeat (150) begin step(); ok &= held_a[1]; end
    check("stretch_held", ok, 1);
    out_a[1] = 1'b0;
    step();
    check("held_forced_off", held_a[1], 0);
    out_a[1] = 1'b1;
    step();
    check("held_back_on", held_a[1], 1);
    align();
    drv_a[1] = 1'b0;
    wait_edge(1'b1, 1, 40, lat);
    check("scl_rise_lat", lat, 14);
    check("held_at_rise", held_a[1], 1);
    step();
    check("held_after_rise", held_a[1], 0);

    // Four independent lines, staggered falls, 2 and 3 together.
    for (int j = 0; j < 4; j++) begin tf[j] = -1; nf[j] = 0; nr[j] = 0; end
    align();
    drv_b[0] = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      step();
      if (k == 4) drv_b[1] = 1'b1;
      if (k == 8) drv_b[3:2] = 2'b11;
      for (int j = 0; j < 4; j++) begin
        if (fall_b[j]) begin nf[j]++; tf[j] = k; end
        if (rise_b[j]) nr[j]++;
      end
    end
    check("mc_fall_t0", tf[0], 14);
    check("mc_fall_t1", tf[1], 18);
    check("mc_fall_t2", tf[2], 22);
    check("mc_fall_t3", tf[3], 22);
    for (int j = 0; j < 4; j++) begin
      check($sformatf("mc_nfall%0d", j), nf[j], 1);
      check($sformatf("mc_nrise%0d", j), nr[j], 0);
    end
    check("mc_flt_low", flt_b, 4'h0);
    for (int j = 0; j < 4; j++) begin tf[j] = -1; nf[j] = 0; nr[j] = 0; end
    repeat (2) step();
    align();
    drv_b = 4'h0;
    for (int k = 1; k <= 20; k++) begin
      step();
      for (int j = 0; j < 4; j++) begin
        if (rise_b[j]) begin nr[j]++; tf[j] = k; end
        if (fall_b[j]) nf[j]++;
      end
    end
    for (int j = 0; j < 4; j++) begin
      check($sformatf("mc_rise_t%0d", j), tf[j], 14);
      check($sformatf("mc_nrise_b%0d", j), nr[j], 1);
      check($sformatf("mc_nfall_b%0d", j), nf[j], 0);
    end
    check("mc_flt_high", flt_b, 4'hf);

    // Async reset while line 0 integrates upward (cnt = 1).
    align();
    drv_a[0] = 1'b1;
    repeat (20) step();
    check("pre_rst_flt", flt_a[0], 0);
    check("pre_rst_held", held_a[0], 1);
    align();
    drv_a[0] = 1'b0;
    repeat (5) step();
    #2;
    reset = 1'b1;
    #1;
    check("async_flt_a", flt_a, 2'b11);
    check("async_held_a", held_a, 0);
    check("async_rise_a", rise_a, 0);
    check("async_fall_a", fall_a, 0);
    check("async_flt_b", flt_b, 4'hf);
    step();
    reset = 1'b0;
    align();
    drv_a[0] = 1'b1;
    wait_edge(1'b0, 0, 40, lat);
    check("post_rst_fall_lat", lat, 14);
    drv_a[0] = 1'b0;
    repeat (4) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/i2c_line_bank.md
Name: i2c_line_bank

Overview:
- Parametrised successor of the single-pair I2C line conditioner.
- Drives N open-drain lines (SDA/SCL pairs or extra shared lines such as a second bus or an INT line) and resynchronises each line's input with a configurable synchroniser depth.
- Deglitches each input with a per-line saturating integrator that has hysteresis. This replaces the fixed 3-tap majority vote.
- Adds registered edge strobes and a "released-but-held-low" flag per line, so the master FSM can detect clock stretching and arbitration loss.

Parameters:
- N_LINES, 2, number of open-drain lines. Must be >= 1. Bit 0 = SDA and bit 1 = SCL by convention.
- SYN_STAGES, 2, synchroniser flops per line. Must be >= 2.
- FLT_LEN, 3, integrator saturation value in ticks. Must be >= 1.
- IDLE_LEVEL, 1, reset value of synchronisers, integrators and filtered outputs. 1 = bus idle high.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous reset, active-high
- tickX16  input  1  one-clk sample strobe, 16x the bus bit rate
- lineOut  input  N_LINES  per-line drive control: 1 = release (z), 0 = pull low
- lineFlt  output  N_LINES  filtered line level, registered
- lineRise  output  N_LINES  one-clk strobe: lineFlt went 0->1
- lineFall  output  N_LINES  one-clk strobe: lineFlt went 1->0
- lineHeld  output  N_LINES  registered: line released (lineOut=1) but lineFlt=0
- lines  inout  N_LINES  open-drain bus lines (wire)

Behaviour:
- Tri-state: lines[i] = lineOut[i] ? z : 0. This path is combinational with no delay. The input is read from the pin, never from lineOut.
- Reset (async):
  - all synchroniser flops = IDLE_LEVEL;
  - counters = IDLE_LEVEL ? FLT_LEN : 0;
  - lineFlt = IDLE_LEVEL;
  - lineRise = lineFall = lineHeld = 0.
- Synchroniser: a SYN_STAGES-deep shift register per line, clocked every clk. syn[i] is the last stage.
- Integrator:
  - Counter width is $clog2(FLT_LEN+1). It updates only on a clk where tickX16=1.
  - syn=1 and cnt<FLT_LEN: cnt+1. syn=0 and cnt>0: cnt-1. Otherwise hold, so the counter never wraps.
- Hysteresis:
  - lineFlt is set to 1 on the clk after cnt reaches FLT_LEN.
  - lineFlt is cleared to 0 on the clk after cnt reaches 0.
  - Otherwise lineFlt holds.
  - Any glitch shorter than FLT_LEN ticks, on a stable level, never toggles lineFlt.
- Latency, clean step held long enough:
  - syn settles SYN_STAGES clks after the pin edge;
  - after that, lineFlt changes one clk after the FLT_LEN-th tick.
- Edges: lineRise/lineFall are asserted for exactly one clk, the same clk lineFlt takes its new value. They are mutually exclusive per line.
- Held detect: lineHeld[i] <= lineOut[i] & ~lineFlt[i], evaluated every clk and registered.
  - Release of a line the bank itself drove low shows lineHeld=1 until the filter catches up, at most SYN_STAGES + FLT_LEN ticks + 2 clks. Consumers must qualify it with their own timeout.
  - lineOut=0 forces lineHeld=0 on the next clk.
- tickX16 stuck 0: counters and lineFlt freeze; synchronisers still run.
- tickX16 stuck 1: the filter runs at the clk rate. This is legal.
- Lines are fully independent. There is no cross-line coupling, and simultaneous events on several lines are handled in parallel.
- Reset mid-transition restores idle values immediately. The first filter decision after reset needs a full FLT_LEN ticks of the opposite level.

Test Plan:
1. Reset: N_LINES=2, IDLE_LEVEL=1 -> lineFlt=2'b11, Rise/Fall/Held=0, lines=z while lineOut=2'b11.
2. Clean fall, FLT_LEN=3, tick every 4 clks: pin 0 held -> lineFall[0] single pulse, lineFlt[0]=0 one clk after the 3rd tick following sync. Release -> lineRise[0] after 3 more ticks.
3. Glitch: a 2-tick low pulse on a high line (FLT_LEN=3) -> no Fall, lineFlt stays 1, counter returns to 3.
4. Stretch: lineOut[1]=1 while the bench holds the pin low for 40 ticks -> lineHeld[1]=1 throughout. It clears 1 clk after lineFlt[1] rises.
5. Multi-channel: N_LINES=4, SYN_STAGES=3, distinct staggered edges plus one simultaneous fall on lines 2 and 3 -> independent correct strobes, identical timing on lines 2 and 3, no cross-talk.
6. Async reset asserted mid-integration (cnt=1) -> all outputs return to reset values without a clk edge. Counter = FLT_LEN after release.
